// File: rtl/regfile_pkg.sv
// Shared constants, init-state encoding and port-slice helper for the register file.
package regfile_pkg;

    // Init pattern selectors
    localparam int unsigned INIT_ZERO  = 0;
    localparam int unsigned INIT_INDEX = 1;

    // Init engine states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_INIT = 1'b1
    } init_state_e;

    // Low bit of slice k in a packed vector of w-bit port fields
    function automatic int unsigned slice_lo(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/regfile_init_seq.sv
// Sequential init engine: walks every entry once, one write per cycle.
module regfile_init_seq
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned ADDR_SIZE  = 5,
    parameter int unsigned INIT_MODE  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init_req_i,
    output logic                  init_busy_o,
    output logic                  init_done_o,
    output logic [ADDR_SIZE-1:0]  init_waddr_o,
    output logic [DATA_WIDTH-1:0] init_wdata_o
);

    localparam logic [ADDR_SIZE-1:0] LAST_IDX = ADDR_SIZE'(DEPTH - 1);

    init_state_e          state_q;
    logic [ADDR_SIZE-1:0] cnt_q;
    logic                 busy_q;
    logic                 done_q;

    // Init FSM, entry counter and status flags; reset always restarts the walk
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (init_req_i) begin
                        state_q <= ST_INIT;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_INIT: begin
                    if (cnt_q == LAST_IDX) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + ADDR_SIZE'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign init_busy_o  = busy_q;
    assign init_done_o  = done_q;
    assign init_waddr_o = cnt_q;
    assign init_wdata_o = (INIT_MODE == INIT_INDEX) ? DATA_WIDTH'(cnt_q) : '0;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational reads, two write ports,
// optional same-cycle bypass, hardwired zero entry and sequential init.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned ADDR_SIZE  = 5,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned ZERO_REG   = 1,
    parameter int unsigned BYPASS     = 1,
    parameter int unsigned INIT_MODE  = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           we0,
    input  logic [ADDR_SIZE-1:0]           waddr0,
    input  logic [DATA_WIDTH-1:0]          wdata0,
    input  logic                           we1,
    input  logic [ADDR_SIZE-1:0]           waddr1,
    input  logic [DATA_WIDTH-1:0]          wdata1,
    input  logic [NUM_RD*ADDR_SIZE-1:0]    rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data,
    input  logic                           init_req,
    output logic                           init_busy,
    output logic                           init_done,
    output logic                           wr_drop
);

    localparam int unsigned AW1 = ADDR_SIZE + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  init_busy_w;
    logic [ADDR_SIZE-1:0]  init_waddr_w;
    logic [DATA_WIDTH-1:0] init_wdata_w;

    logic acc0_c;
    logic acc1_c;
    logic collide_c;
    logic wr_drop_d;
    logic wr_drop_q;

    // Address lies inside the implemented storage
    function automatic logic addr_ok(input logic [ADDR_SIZE-1:0] a);
        return {1'b0, a} < AW1'(DEPTH);
    endfunction

    // Address is the hardwired zero entry
    function automatic logic is_zero(input logic [ADDR_SIZE-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    regfile_init_seq #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_SIZE  (ADDR_SIZE),
        .INIT_MODE  (INIT_MODE)
    ) u_init_seq (
        .clk          (clk),
        .rst          (rst),
        .init_req_i   (init_req),
        .init_busy_o  (init_busy_w),
        .init_done_o  (init_done),
        .init_waddr_o (init_waddr_w),
        .init_wdata_o (init_wdata_w)
    );

    // Write acceptance and drop detection; port 1 wins a same-address collision
    always_comb begin
        acc0_c    = 1'b0;
        acc1_c    = 1'b0;
        collide_c = 1'b0;
        wr_drop_d = 1'b0;
        if (init_busy_w) begin
            wr_drop_d = we0 | we1;
        end else begin
            collide_c = we0 && we1 && (waddr0 == waddr1);
            acc1_c    = we1 && addr_ok(waddr1) && !is_zero(waddr1);
            acc0_c    = we0 && addr_ok(waddr0) && !is_zero(waddr0) && !collide_c;
            wr_drop_d = (we0 && !addr_ok(waddr0))
                     || (we1 && !addr_ok(waddr1))
                     || (collide_c && addr_ok(waddr0) && !is_zero(waddr0));
        end
    end

    // Storage update: init engine has priority, storage is never bulk-reset
    always_ff @(posedge clk) begin
        if (rst) begin
            if (init_busy_w) begin
                mem_q[init_waddr_w] <= init_wdata_w;
            end else begin
                if (acc0_c) mem_q[waddr0] <= wdata0;
                if (acc1_c) mem_q[waddr1] <= wdata1;
            end
        end
    end

    // Drop pulse register
    always_ff @(posedge clk) begin
        if (!rst) wr_drop_q <= 1'b0;
        else      wr_drop_q <= wr_drop_d;
    end

    // Per-port combinational read with zero, range, bypass priority
    for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
        localparam int unsigned ALO = slice_lo(k, ADDR_SIZE);
        localparam int unsigned DLO = slice_lo(k, DATA_WIDTH);

        logic [ADDR_SIZE-1:0]  ra;
        logic [DATA_WIDTH-1:0] rv;

        assign ra = rd_addr[ALO +: ADDR_SIZE];

        // Read mux for this port
        always_comb begin
            rv = '0;
            if (init_busy_w) begin
                rv = '0;
            end else if (is_zero(ra)) begin
                rv = '0;
            end else if (!addr_ok(ra)) begin
                rv = '0;
            end else if ((BYPASS != 0) && acc1_c && (waddr1 == ra)) begin
                rv = wdata1;
            end else if ((BYPASS != 0) && acc0_c && (waddr0 == ra)) begin
                rv = wdata0;
            end else begin
                rv = mem_q[ra];
            end
        end

        assign rd_data[DLO +: DATA_WIDTH] = rv;
    end

    assign init_busy = init_busy_w;
    assign wr_drop   = wr_drop_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a bypassing instance and a non-bypassing twin.
module tb_regfile_mp;

    logic        clk;
    logic        rst;
    logic        we0;
    logic [4:0]  waddr0;
    logic [31:0] wdata0;
    logic        we1;
    logic [4:0]  waddr1;
    logic [31:0] wdata1;
    logic [9:0]  rd_addr;
    logic        init_req;

    logic [63:0] rd_data;
    logic        init_busy;
    logic        init_done;
    logic        wr_drop;

    logic [63:0] nb_rd_data;
    logic        nb_init_busy;
    logic        nb_init_done;
    logic        nb_wr_drop;

    int n_tests;
    int n_fail;

    regfile_mp #(
        .DATA_WIDTH (32), .DEPTH (32), .ADDR_SIZE (5), .NUM_RD (2),
        .ZERO_REG (1), .BYPASS (1), .INIT_MODE (1)
    ) dut (
        .clk (clk), .rst (rst),
        .we0 (we0), .waddr0 (waddr0), .wdata0 (wdata0),
        .we1 (we1), .waddr1 (waddr1), .wdata1 (wdata1),
        .rd_addr (rd_addr), .rd_data (rd_data),
        .init_req (init_req), .init_busy (init_busy),
        .init_done (init_done), .wr_drop (wr_drop)
    );

    regfile_mp #(
        .DATA_WIDTH (32), .DEPTH (32), .ADDR_SIZE (5), .NUM_RD (2),
        .ZERO_REG (1), .BYPASS (0), .INIT_MODE (1)
    ) dut_nb (
        .clk (clk), .rst (rst),
        .we0 (we0), .waddr0 (waddr0), .wdata0 (wdata0),
        .we1 (we1), .waddr1 (waddr1), .wdata1 (wdata1),
        .rd_addr (rd_addr), .rd_data (nb_rd_data),
        .init_req (init_req), .init_busy (nb_init_busy),
        .init_done (nb_init_done), .wr_drop (nb_wr_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
        #1;
    endtask

    task automatic idle_inputs();
        we0 = 1'b0; waddr0 = '0; wdata0 = '0;
        we1 = 1'b0; waddr1 = '0; wdata1 = '0;
        init_req = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        idle_inputs();
        rd_addr = '0;
        rst = 1'b0;

        // 1: reset for 3 cycles, then 32 init cycles
        repeat (3) tick();
        set_rd(5'd7, 5'd31);
        chk("rst_busy", 32'(init_busy), 32'd1);
        chk("rst_done", 32'(init_done), 32'd0);
        chk("rst_drop", 32'(wr_drop), 32'd0);
        chk("rst_rd0", rd_data[31:0], 32'd0);
        rst = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            tick();
            chk($sformatf("init_busy_%0d", i), 32'(init_busy), (i < 32) ? 32'd1 : 32'd0);
            chk($sformatf("init_done_%0d", i), 32'(init_done), (i == 32) ? 32'd1 : 32'd0);
        end
        tick();
        chk("init_done_drop", 32'(init_done), 32'd0);
        set_rd(5'd7, 5'd31);
        chk("init_rd7", rd_data[31:0], 32'd7);
        chk("init_rd31", rd_data[63:32], 32'd31);
        chk("init_nb_rd7", nb_rd_data[31:0], 32'd7);

        // 2: same-cycle bypass vs stored value
        we0 = 1'b1; waddr0 = 5'd8; wdata0 = 32'hDEADBEEF;
        set_rd(5'd8, 5'd1);
        chk("byp_on", rd_data[31:0], 32'hDEADBEEF);
        chk("byp_off", nb_rd_data[31:0], 32'd8);
        chk("byp_other", rd_data[63:32], 32'd1);
        tick();
        idle_inputs();
        set_rd(5'd8, 5'd1);
        chk("wr8_on", rd_data[31:0], 32'hDEADBEEF);
        chk("wr8_off", nb_rd_data[31:0], 32'hDEADBEEF);
        chk("wr8_drop", 32'(wr_drop), 32'd0);

        // 3: same-address collision, port 1 wins
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h11;
        we1 = 1'b1; waddr1 = 5'd5; wdata1 = 32'h22;
        set_rd(5'd5, 5'd6);
        chk("coll_byp", rd_data[31:0], 32'h22);
        tick();
        idle_inputs();
        set_rd(5'd5, 5'd6);
        chk("coll_drop", 32'(wr_drop), 32'd1);
        chk("coll_rd5", rd_data[31:0], 32'h22);
        chk("coll_nb_rd5", nb_rd_data[31:0], 32'h22);
        chk("coll_rd6", rd_data[63:32], 32'd6);
        tick();
        chk("coll_drop_end", 32'(wr_drop), 32'd0);

        // 4: zero register ignores writes silently
        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFFFFFF;
        set_rd(5'd0, 5'd0);
        chk("zero_byp", rd_data[31:0], 32'd0);
        tick();
        idle_inputs();
        set_rd(5'd0, 5'd0);
        chk("zero_rd", rd_data[31:0], 32'd0);
        chk("zero_nb_rd", nb_rd_data[63:32], 32'd0);
        chk("zero_drop", 32'(wr_drop), 32'd0);

        // Dual write to distinct addresses, bypass on both read ports
        we0 = 1'b1; waddr0 = 5'd9;  wdata0 = 32'h0000AAAA;
        we1 = 1'b1; waddr1 = 5'd10; wdata1 = 32'h0000BBBB;
        set_rd(5'd9, 5'd10);
        chk("dual_byp0", rd_data[31:0], 32'h0000AAAA);
        chk("dual_byp1", rd_data[63:32], 32'h0000BBBB);
        chk("dual_nb1", nb_rd_data[63:32], 32'd10);
        tick();
        idle_inputs();
        set_rd(5'd9, 5'd10);
        chk("dual_drop", 32'(wr_drop), 32'd0);
        chk("dual_rd9", nb_rd_data[31:0], 32'h0000AAAA);
        chk("dual_rd10", nb_rd_data[63:32], 32'h0000BBBB);

        // 5: re-init on request; writes during INIT are dropped
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        set_rd(5'd8, 5'd9);
        chk("req_busy", 32'(init_busy), 32'd1);
        chk("req_rd_zero0", rd_data[31:0], 32'd0);
        chk("req_rd_zero1", nb_rd_data[63:32], 32'd0);
        repeat (9) tick();
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h00001234;
        init_req = 1'b1;
        set_rd(5'd3, 5'd3);
        chk("busy_wr_rd", rd_data[31:0], 32'd0);
        tick();
        idle_inputs();
        chk("busy_drop", 32'(wr_drop), 32'd1);
        chk("busy_still", 32'(init_busy), 32'd1);
        tick();
        chk("busy_drop_end", 32'(wr_drop), 32'd0);
        for (int i = 12; i <= 32; i++) begin
            tick();
            chk($sformatf("req_busy_%0d", i), 32'(init_busy), (i < 32) ? 32'd1 : 32'd0);
            chk($sformatf("req_done_%0d", i), 32'(init_done), (i == 32) ? 32'd1 : 32'd0);
        end
        tick();
        chk("req_done_drop", 32'(init_done), 32'd0);
        set_rd(5'd3, 5'd8);
        chk("req_rd3", rd_data[31:0], 32'd3);
        chk("req_rd8", rd_data[63:32], 32'd8);
        chk("req_nb_rd8", nb_rd_data[63:32], 32'd8);

        // 6: reset at cnt=20 restarts the walk with a single done pulse
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        repeat (20) tick();
        chk("mid_busy", 32'(init_busy), 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mid_rst_busy", 32'(init_busy), 32'd1);
        chk("mid_rst_done", 32'(init_done), 32'd0);
        for (int i = 1; i <= 32; i++) begin
            tick();
            chk($sformatf("mid_busy_%0d", i), 32'(init_busy), (i < 32) ? 32'd1 : 32'd0);
            chk($sformatf("mid_done_%0d", i), 32'(init_done), (i == 32) ? 32'd1 : 32'd0);
        end
        tick();
        chk("mid_done_drop", 32'(init_done), 32'd0);
        set_rd(5'd20, 5'd31);
        chk("mid_rd20", rd_data[31:0], 32'd20);
        chk("mid_rd31", rd_data[63:32], 32'd31);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file for the MIPS32 datapath and its planned pipelined variant. It provides NUM_RD combinational read ports and two write ports. It adds same-cycle write-to-read bypass, a hardwired zero register, and a sequential init engine. The init engine loads every entry one per cycle after reset or on request, so storage needs no parallel reset.

Parameters:
DATA_WIDTH, 32, width of each register
DEPTH, 32, number of registers
ADDR_SIZE, 5, address width (DEPTH <= 2**ADDR_SIZE)
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes
BYPASS, 1, 1 = read returns same-cycle write data
INIT_MODE, 1, 0 = load zeros; 1 = load entry i with value i

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-low reset
we0  in  1  write enable, port 0
waddr0  in  ADDR_SIZE  write address, port 0
wdata0  in  DATA_WIDTH  write data, port 0
we1  in  1  write enable, port 1
waddr1  in  ADDR_SIZE  write address, port 1
wdata1  in  DATA_WIDTH  write data, port 1
rd_addr  in  NUM_RD*ADDR_SIZE  packed read addresses, port k at [k*ADDR_SIZE +: ADDR_SIZE]
rd_data  out  NUM_RD*DATA_WIDTH  packed read data, same packing
init_req  in  1  one-cycle request to re-run the init sequence
init_busy  out  1  init sequence in progress
init_done  out  1  one-cycle pulse when init completes
wr_drop  out  1  one-cycle pulse: an enabled write was discarded

Behaviour:
- Reset (rst=0 at clk edge):
  - Init counter <= 0, init_busy <= 1, init_done <= 0, wr_drop <= 0.
  - Storage is not touched directly.
- Init engine, states IDLE and INIT:
  - INIT: each edge writes the pattern to entry cnt, then cnt <= cnt+1.
  - After the edge that writes entry DEPTH-1: go to IDLE, init_busy <= 0, init_done <= 1 for exactly one cycle.
  - After rst is released, init_busy stays high for exactly DEPTH cycles.
  - IDLE with init_req=1: go to INIT next edge, cnt=0, init_busy=1.
  - init_req while busy is ignored.
  - rst low mid-sequence restarts at cnt=0.
- While init_busy=1:
  - All external writes are ignored. wr_drop pulses the cycle after any ignored write with we0 or we1 = 1.
  - rd_data reads 0 on all ports.
- Writes (IDLE only), registered on rising edge:
  - Both ports enabled to the same address: port 1 wins and wr_drop pulses.
  - Writes to addresses >= DEPTH are discarded with a wr_drop pulse.
  - ZERO_REG=1: writes to address 0 are silently discarded, with no wr_drop.
- Reads are combinational from storage, evaluated per port in this order:
  1. ZERO_REG=1 and address 0 returns 0.
  2. Address >= DEPTH returns 0.
  3. BYPASS=1 and a same-cycle accepted write hits the address: return that wdata, port 1 over port 0.
  4. Otherwise return the stored value.
- No arithmetic beyond the ADDR_SIZE-bit counter. The counter compares against DEPTH-1 and does not wrap.

Decomposition:
- Package regfile_pkg holds:
  - INIT_ZERO and INIT_INDEX constants
  - the init-state encoding (IDLE=1'b0, INIT=1'b1)
  - a pack/unpack helper function for port slices
- One sub-module, regfile_init_seq, contains the counter, FSM, init_busy, init_done and the init write address/data. regfile_mp muxes the init write into storage ahead of the external write ports.

Test Plan:
1. Hold rst=0 for 3 cycles, then release -> init_busy=1 for exactly 32 cycles. init_done pulses on cycle 32. Afterwards reading addr 7 gives 7 and addr 31 gives 31 (INIT_MODE=1).
2. After init: we0=1, waddr0=8, wdata0=0xDEADBEEF, rd_addr port0=8 in the same cycle -> rd_data0=0xDEADBEEF with BYPASS=1, and the old value 8 with BYPASS=0. Next cycle reads 0xDEADBEEF in both cases.
3. we0 and we1 both to addr 5, data 0x11 and 0x22 -> addr 5 holds 0x22 and wr_drop pulses once.
4. Write 0xFFFFFFFF to addr 0 -> reads stay 0 and wr_drop stays 0 (ZERO_REG=1).
5. Pulse init_req, then on cycle 10 of INIT assert we0 to addr 3 -> write ignored, wr_drop pulses, rd_data=0 while busy. After done, addr 3 = 3.
6. Drop rst for 1 cycle at cnt=20 -> sequence restarts. init_busy lasts 32 more cycles and init_done pulses only once.
